// File: rtl/ring_router_core_p.sv
// ring_router_core_p: parametrised token-ring router core; define RING_TOKEN_TIMEOUT_EN for master token regeneration after TIMEOUT idle cycles
module ring_router_core_p #(
  parameter int ADDR_W = 4,
  parameter int PAYLOAD_W = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST = 2,
  parameter int TIMEOUT = 1024,
  localparam int FRAME_W = 2 + 2 * ADDR_W + PAYLOAD_W
) (
  input  logic                          Clk_R,
  input  logic                          Rst,
  input  logic [ADDR_W-1:0]             r_addr,
  input  logic                          Is_Master,
  input  logic [ADDR_W+PAYLOAD_W-1:0]   Packet_From_Node,
  input  logic                          Packet_From_Node_Valid,
  output logic                          Core_Load_Ack,
  output logic [ADDR_W+PAYLOAD_W-1:0]   Packet_To_Node,
  output logic                          Packet_To_Node_Valid,
  input  logic                          Packet_To_Node_Ready,
  input  logic [FRAME_W-1:0]            RX_Data,
  input  logic                          RX_Data_Valid,
  output logic                          RX_Data_Ready,
  output logic [FRAME_W-1:0]            TX_Data,
  output logic                          TX_Data_Valid,
  input  logic                          TX_Data_Ready,
  output logic                          Nack,
  output logic [7:0]                    Drop_Count
);
  localparam int PKT_W = ADDR_W + PAYLOAD_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  typedef enum logic [2:0] {INIT, IDLE, CLASSIFY, SEND_DATA, PASS_TOKEN, FORWARD, DELIVER, DROP} state_t;
  state_t state;
  logic [PKT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic ack_q, wr_en, rd_en, full, empty, last_pop, timeout;
  logic [PKT_W-1:0] head_pkt, next_pkt;
  logic [FRAME_W-1:0] frame, head_frame, next_frame, token_frame;
  logic [1:0] f_type;
  logic [ADDR_W-1:0] f_dst, f_src;
  logic [PAYLOAD_W-1:0] f_pay;
  logic [BW-1:0] burst_cnt;

  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign wr_en = Packet_From_Node_Valid && !full && !ack_q && !Rst;
  assign Core_Load_Ack = wr_en;
  assign rd_en = state == SEND_DATA && TX_Data_Valid && TX_Data_Ready;
  assign last_pop = count == (AW+1)'(1) && !wr_en;
  assign head_pkt = mem[rd_ptr];
  assign next_pkt = count == (AW+1)'(1) ? Packet_From_Node : mem[rd_ptr + 1'b1];
  assign head_frame = {2'b01, head_pkt[PKT_W-1 -: ADDR_W], r_addr, head_pkt[PAYLOAD_W-1:0]};
  assign next_frame = {2'b01, next_pkt[PKT_W-1 -: ADDR_W], r_addr, next_pkt[PAYLOAD_W-1:0]};
  assign token_frame = {2'b00, {ADDR_W{1'b0}}, r_addr, {PAYLOAD_W{1'b0}}};
  assign f_type = frame[FRAME_W-1 -: 2];
  assign f_dst = frame[FRAME_W-3 -: ADDR_W];
  assign f_src = frame[PAYLOAD_W +: ADDR_W];
  assign f_pay = frame[PAYLOAD_W-1:0];

  always_ff @(posedge Clk_R)
    if (wr_en) mem[wr_ptr] <= Packet_From_Node;

  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ack_q <= 1'b0;
    end else begin
      ack_q <= wr_en;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end

`ifdef RING_TOKEN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  assign timeout = state == IDLE && Is_Master && !RX_Data_Valid && to_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge Clk_R) begin
    if (Rst || (RX_Data_Valid && RX_Data_Ready) || timeout) to_cnt <= '0;
    else if (state == IDLE) to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge Clk_R) begin
    if (Rst) begin
      state <= INIT;
      TX_Data <= '0;
      TX_Data_Valid <= 1'b0;
      RX_Data_Ready <= 1'b0;
      Packet_To_Node <= '0;
      Packet_To_Node_Valid <= 1'b0;
      Nack <= 1'b0;
      Drop_Count <= '0;
      frame <= '0;
      burst_cnt <= '0;
    end else begin
      Nack <= 1'b0;
      case (state)
        INIT: begin
          if (Is_Master) begin
            TX_Data <= {2'b00, r_addr, r_addr, {PAYLOAD_W{1'b0}}};
            state <= PASS_TOKEN;
          end else begin
            RX_Data_Ready <= 1'b1;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (RX_Data_Valid) begin
            frame <= RX_Data;
            RX_Data_Ready <= 1'b0;
            state <= CLASSIFY;
          end else if (timeout) begin
            TX_Data <= token_frame;
            TX_Data_Valid <= 1'b1;
            RX_Data_Ready <= 1'b0;
            state <= PASS_TOKEN;
          end
        end
        CLASSIFY: begin
          if (f_type == 2'b00 && !empty) begin
            TX_Data <= head_frame;
            TX_Data_Valid <= 1'b1;
            burst_cnt <= '0;
            state <= SEND_DATA;
          end else if (f_type == 2'b00) begin
            TX_Data <= token_frame;
            TX_Data_Valid <= 1'b1;
            state <= PASS_TOKEN;
          end else if (f_type == 2'b01 && f_dst == r_addr) begin
            Packet_To_Node <= {f_src, f_pay};
            Packet_To_Node_Valid <= 1'b1;
            state <= DELIVER;
          end else if (f_type == 2'b01 && f_src != r_addr) begin
            TX_Data <= frame;
            TX_Data_Valid <= 1'b1;
            state <= FORWARD;
          end else begin
            Nack <= 1'b1;
            Drop_Count <= Drop_Count + {7'b0, Drop_Count != 8'hFF};
            state <= DROP;
          end
        end
        SEND_DATA: begin
          if (TX_Data_Ready) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BW'(MAX_BURST - 1) || last_pop) begin
              TX_Data <= token_frame;
              state <= PASS_TOKEN;
            end else TX_Data <= next_frame;
          end
        end
        PASS_TOKEN: begin
          if (TX_Data_Valid && TX_Data_Ready) begin
            TX_Data_Valid <= 1'b0;
            RX_Data_Ready <= 1'b1;
            state <= IDLE;
          end else TX_Data_Valid <= 1'b1;
        end
        FORWARD: begin
          if (TX_Data_Ready) begin
            TX_Data_Valid <= 1'b0;
            RX_Data_Ready <= 1'b1;
            state <= IDLE;
          end
        end
        DELIVER: begin
          if (Packet_To_Node_Ready) begin
            Packet_To_Node_Valid <= 1'b0;
            RX_Data_Ready <= 1'b1;
            state <= IDLE;
          end
        end
        DROP: begin
          RX_Data_Ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: doc/ring_router_core_p.md
# ring_router_core_p

Parametrised token-ring router core, the next generation of the fixed three-node 24-bit router core. It sits between one processor node and its serial transmitter/receiver pair. It buffers outgoing node packets in a FIFO and sends up to `MAX_BURST` of them per token visit. It delivers frames addressed to this node, forwards all other traffic, and drops frames that return to their source, flagging each drop as a NACK.

## Interface
Parameters:
- `ADDR_W`, 4: width of the node address.
- `PAYLOAD_W`, 24: payload width.
- `FIFO_DEPTH`, 4: outgoing packet FIFO depth. Must be a power of 2, at least 2.
- `MAX_BURST`, 2: maximum data frames sent per token hold. Range 1..`FIFO_DEPTH`.
- `TIMEOUT`, 1024: idle cycles before the master regenerates the token. Used only with `RING_TOKEN_TIMEOUT_EN`.
- `FRAME_W`, derived: `2+2*ADDR_W+PAYLOAD_W`. Frame layout is `{type[1:0], dst, src, payload}`. Types: 00 token, 01 data, 1x reserved.

Ports:
- `Clk_R` in 1: core clock. This is the single clock.
- `Rst` in 1: reset. Synchronous, active-high.
- `r_addr` in `ADDR_W`: this node's address. Static after reset.
- `Is_Master` in 1: this node injects the token after reset.
- `Packet_From_Node` in `ADDR_W+PAYLOAD_W`: outgoing packet, `{dst, payload}`.
- `Packet_From_Node_Valid` in 1: outgoing packet valid.
- `Core_Load_Ack` out 1: single-cycle pulse when the packet is written into the FIFO.
- `Packet_To_Node` out `ADDR_W+PAYLOAD_W`: delivered packet, `{src, payload}`.
- `Packet_To_Node_Valid` out 1; `Packet_To_Node_Ready` in 1.
- `RX_Data` in `FRAME_W`; `RX_Data_Valid` in 1; `RX_Data_Ready` out 1.
- `TX_Data` out `FRAME_W`; `TX_Data_Valid` out 1; `TX_Data_Ready` in 1.
- `Nack` out 1: single-cycle pulse when a returned frame is dropped.
- `Drop_Count` out 8: saturating count of dropped frames.

## Operation
- States: `INIT`, `IDLE`, `CLASSIFY`, `SEND_DATA`, `PASS_TOKEN`, `FORWARD`, `DELIVER`, `DROP`.
- FIFO write:
  - Fires when `Packet_From_Node_Valid` is high, the FIFO is not full, and `Core_Load_Ack` was low in the previous cycle.
  - `Core_Load_Ack` pulses the same cycle as the write. The node must change or deassert its packet after the ack.
  - When the FIFO is full, there is no write and no ack, and the node holds its packet.
- `INIT`:
  - Entered on reset.
  - If `Is_Master`, go to `PASS_TOKEN` with the frame set to a token carrying `dst=src=r_addr`.
  - Otherwise go to `IDLE`.
- `IDLE`:
  - `RX_Data_Ready` is 1.
  - When `RX_Data_Valid` is high, latch `RX_Data` into the frame register and go to `CLASSIFY`.
- `CLASSIFY` priorities:
  1. A token with a non-empty FIFO goes to `SEND_DATA`, with `burst_cnt` set to 0.
  2. A token with an empty FIFO goes to `PASS_TOKEN`.
  3. Data with `dst==r_addr` goes to `DELIVER`.
  4. Data with `src==r_addr` (a frame that circled the ring) goes to `DROP`.
  5. Any other data goes to `FORWARD`.
  6. A reserved type goes to `DROP`.
- `SEND_DATA`:
  - `TX_Data` is `{01, fifo_dst, r_addr, payload}`.
  - On handshake: pop the FIFO and increment `burst_cnt`.
  - If `burst_cnt+1==MAX_BURST` or the FIFO becomes empty, go to `PASS_TOKEN`. Otherwise stay in `SEND_DATA`.
- `PASS_TOKEN`: send a token frame `{00, 0, r_addr, 0}`, then go to `IDLE`.
- `FORWARD`: send the latched frame unchanged, then go to `IDLE`.
- `DELIVER`:
  - Drive `Packet_To_Node={src, payload}` with `Packet_To_Node_Valid` high.
  - On handshake, go to `IDLE`.
- `DROP`:
  - Pulse `Nack` and increment `Drop_Count`, saturating at 255.
  - Go to `IDLE`.
- FIFO writes from the node continue in every state. A simultaneous push and pop is allowed and leaves occupancy unchanged.

## Timing
- Reset values: every output is 0, the FIFO is empty, and the state is `INIT`.
- Reset applied mid-operation aborts any transfer. The FIFO contents and any held frame are discarded.
- Master token injection: `TX_Data_Valid` rises 2 cycles after the cycle in which `Rst` is sampled low.
- Forward latency:
  - The RX handshake occurs in cycle N.
  - `CLASSIFY` runs in cycle N+1.
  - `TX_Data_Valid` is high in cycle N+2.
- TX handshake:
  - The transfer completes when `TX_Data_Valid` and `TX_Data_Ready` are both high on a rising edge.
  - `TX_Data` is stable while valid. Valid never drops before the handshake.
- The DELIVER handshake follows the same rules using `Packet_To_Node_Valid` and `Packet_To_Node_Ready`.
- `RX_Data_Ready` is high only in `IDLE`. The ring back-pressures while this node is busy.
- Consecutive frames in one burst are 1 cycle apart when `TX_Data_Ready` stays high.

## Configuration
- `RING_TOKEN_TIMEOUT_EN` defined:
  - A counter clears on every RX handshake and increments while in `IDLE`.
  - When `Is_Master` is set and the counter reaches `TIMEOUT-1`, go to `PASS_TOKEN`, regenerating the token, and clear the counter.
- `RING_TOKEN_TIMEOUT_EN` undefined: no counter is built and a lost token is never recovered.

## Test plan
- Master with an empty FIFO: deassert `Rst`. `TX_Data={00,0,0,0}` is valid 2 cycles later. Hold `TX_Data_Ready` low for 5 cycles; `TX_Data` must stay stable throughout.
- Token burst: `MAX_BURST=2`, with FIFO entries dst=1 payload 42, 100, 7. Receive a token. The node sends two data frames with payloads 42 then 100, then a token. Payload 7 remains in the FIFO.
- Deliver: `r_addr=1`, receive `{01,1,0,69}` while `Packet_To_Node_Ready` is low for 3 cycles. `Packet_To_Node={0,69}` is held valid, and `RX_Data_Ready` stays 0 until the handshake.
- Forward and drop:
  - `r_addr=2`, receive `{01,1,0,5}`: the frame is forwarded unchanged with `TX_Data_Valid` high at N+2.
  - `r_addr=2`, receive `{01,3,2,5}`: `Nack` pulses once and `Drop_Count` becomes 1.
- FIFO full: push 5 packets with `FIFO_DEPTH=4`. Exactly 4 `Core_Load_Ack` pulses occur. Apply `Rst` for 1 cycle; the FIFO empties and every output returns to 0.
- With `RING_TOKEN_TIMEOUT_EN` and `TIMEOUT=16`: master, no RX traffic after its first token. A new token appears 16 cycles after entering `IDLE`.
